// File: rtl/writeback_queue.sv
// writeback_queue: in-order write-back FIFO serialising ALU/load results onto the register file write port
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int DATA_W = 32,
    parameter int REG_ADDR_W = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]     alu_result,
    output logic                  in_ready,
    output logic [DATA_W-1:0]     data_in,
    output logic [REG_ADDR_W-1:0] decoder_control,
    output logic                  load_enable,
    input  logic [REG_ADDR_W-1:0] a_select,
    input  logic [REG_ADDR_W-1:0] b_select,
    output logic                  a_pending,
    output logic                  b_pending,
    output logic [CW-1:0]         count
);
    logic [DATA_W-1:0]     r_data [DEPTH];
    logic [REG_ADDR_W-1:0] r_rd [DEPTH];
    logic [AW-1:0]         r_wptr, r_rptr;
    logic [CW-1:0]         r_count;
    logic [DATA_W-1:0]     r_data_in;
    logic [REG_ADDR_W-1:0] r_dc;
    logic                  r_le;
    logic                  w_in_ready, w_enq_m, w_enq_a, w_pop;
    logic [AW-1:0]         w_alu_ptr;
    logic [CW-1:0]         w_n_enq;
    logic [AW-1:0]         w_off [DEPTH];
    logic [DEPTH-1:0]      w_occ, w_a_hit, w_b_hit;

    assign w_in_ready = r_count <= CW'(DEPTH - 2);
    assign w_enq_m    = w_in_ready && mem_valid;
    assign w_enq_a    = w_in_ready && alu_valid;
    assign w_pop      = r_count != '0;
    assign w_alu_ptr  = r_wptr + AW'(w_enq_m);
    assign w_n_enq    = CW'(w_enq_m) + CW'(w_enq_a);

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign w_off[i]   = AW'(i) - r_rptr;
        assign w_occ[i]   = {1'b0, w_off[i]} < r_count;
        assign w_a_hit[i] = r_rd[i] == a_select;
        assign w_b_hit[i] = r_rd[i] == b_select;
    end

    assign a_pending       = |(w_occ & w_a_hit) || (r_le && r_dc == a_select);
    assign b_pending       = |(w_occ & w_b_hit) || (r_le && r_dc == b_select);
    assign in_ready        = w_in_ready;
    assign data_in         = r_data_in;
    assign decoder_control = r_dc;
    assign load_enable     = r_le;
    assign count           = r_count;

    // Entry storage: mem lands first (older instruction), alu right behind it
    always_ff @(posedge clk) begin
        if (w_enq_m) begin
            r_data[r_wptr] <= mem_data;
            r_rd[r_wptr]   <= mem_rd;
        end
        if (w_enq_a) begin
            r_data[w_alu_ptr] <= alu_result;
            r_rd[w_alu_ptr]   <= alu_rd;
        end
    end

    // Pointers, occupancy and the registered write port; head pops whenever occupied
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_data_in <= '0;
            r_dc      <= '0;
            r_le      <= 1'b0;
        end else begin
            if (w_pop) begin
                r_data_in <= r_data[r_rptr];
                r_dc      <= r_rd[r_rptr];
                r_rptr    <= r_rptr + 1'b1;
            end
            r_le    <= w_pop;
            r_wptr  <= r_wptr + AW'(w_n_enq);
            r_count <= r_count + w_n_enq - CW'(w_pop);
        end
    end
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: scoreboard bench for the write-back queue
module tb_writeback_queue;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_valid, alu_valid;
    logic [3:0]  mem_rd, alu_rd, a_select, b_select, decoder_control;
    logic [31:0] mem_data, alu_result, data_in;
    logic        in_ready, load_enable, a_pending, b_pending;
    logic [2:0]  count;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_count = 0;
    logic [35:0] sb[$];

    writeback_queue dut (
        .clk(clk), .reset_n(reset_n),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result),
        .in_ready(in_ready), .data_in(data_in), .decoder_control(decoder_control),
        .load_enable(load_enable), .a_select(a_select), .b_select(b_select),
        .a_pending(a_pending), .b_pending(b_pending), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic mv, input logic [3:0] mr, input logic [31:0] md,
                        input logic av, input logic [3:0] ar, input logic [31:0] ad);
        logic        le_exp;
        int          n;
        logic [35:0] e;
        mem_valid = mv; mem_rd = mr; mem_data = md;
        alu_valid = av; alu_rd = ar; alu_result = ad;
        le_exp = m_count > 0;
        n = 0;
        check("in_ready", in_ready, m_count <= 2);
        if (m_count <= 2) begin
            if (mv) begin sb.push_back({mr, md}); n++; end
            if (av) begin sb.push_back({ar, ad}); n++; end
        end
        @(posedge clk);
        #1;
        m_count = m_count + n - (le_exp ? 1 : 0);
        check("count", count, m_count);
        check("load_enable", load_enable, le_exp);
        if (load_enable) begin
            if (sb.size() == 0) check("sb_underflow", 1, 0);
            else begin
                e = sb.pop_front();
                check("wr_rd", decoder_control, e[35:32]);
                check("wr_data", data_in, e[31:0]);
            end
        end
        mem_valid = 0; alu_valid = 0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset_n = 0; mem_valid = 0; alu_valid = 0;
        mem_rd = 0; alu_rd = 0; mem_data = 0; alu_result = 0;
        a_select = 0; b_select = 0;
        #3;
        check("rst_count", count, 0);
        check("rst_le", load_enable, 0);
        check("rst_ready", in_ready, 1);
        @(negedge clk) reset_n = 1;

        // single ALU write to r0
        step(0, 0, 0, 1, 0, 32'h1);
        check("a_pend_q", a_pending, 1);
        step(0, 0, 0, 0, 0, 0);
        check("a_pend_fly", a_pending, 1);
        step(0, 0, 0, 0, 0, 0);
        check("a_pend_clr", a_pending, 0);

        // dual issue to the same register: A then B
        step(1, 7, 32'hA, 1, 7, 32'hB);
        idle(3);

        // fill, backpressure with a dropped request, pending on deep entries
        step(1, 5, 32'h55, 1, 6, 32'h66);
        step(1, 8, 32'h88, 1, 9, 32'h99);
        a_select = 9; b_select = 5;
        #1;
        check("a_pend_tail", a_pending, 1);
        check("b_pend_fly", b_pending, 1);
        a_select = 2;
        #1;
        check("a_pend_none", a_pending, 0);
        step(1, 12, 32'hC, 1, 12, 32'hC);
        idle(4);

        // ten spaced single writes crossing the pointer wrap
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 4'(i), 32'h100 + i);
        idle(2);
        check("drain_count", count, 0);
        check("drain_le", load_enable, 0);

        // per-port pending
        step(0, 0, 0, 1, 12, 32'h1234);
        a_select = 12; b_select = 3;
        #1;
        check("pp_a", a_pending, 1);
        check("pp_b", b_pending, 0);
        a_select = 3; b_select = 12;
        #1;
        check("pp_a_sw", a_pending, 0);
        check("pp_b_sw", b_pending, 1);
        idle(2);
        check("pp_a_done", a_pending, 0);
        check("pp_b_done", b_pending, 0);

        // reset mid-stream with three entries queued
        step(1, 1, 32'hD1, 1, 2, 32'hD2);
        step(1, 3, 32'hD3, 1, 4, 32'hD4);
        a_select = 4; b_select = 3;
        #2 reset_n = 0;
        #1;
        check("mrst_count", count, 0);
        check("mrst_le", load_enable, 0);
        check("mrst_data", data_in, 0);
        check("mrst_dc", decoder_control, 0);
        check("mrst_a", a_pending, 0);
        check("mrst_b", b_pending, 0);
        check("mrst_ready", in_ready, 1);
        sb.delete();
        m_count = 0;
        @(negedge clk) reset_n = 1;
        idle(4);

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
